// File: rtl/yuv_addr_gen.sv
// yuv_addr_gen: pipelined pixel-to-frame-buffer address generator for planar YUV.
//
// A (row, col) coordinate goes in and comes out two cycles later with:
//   - Y, U and V word addresses
//   - the bit offset of the sample inside its memory word
// Chroma can be 4:2:0 or 4:2:2, chosen per beat at run time.
// Coordinates come either from the request handshake or from the built-in
// full-frame raster scanner.
//
// Optional feature macro: YUV_ADDR_BOUNDS_CHECK_EN
//   When defined, an out-of-range coordinate raises out_err and forces all
//   addresses and offsets of that beat to zero.
//   When undefined, out_err is tied low and the arithmetic wraps unchecked.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | request port open; a start pulse with no accepted request enters SCAN
// SCAN  | request port closed; one raster coordinate is inserted per pipeline advance

module yuv_addr_gen #(
  parameter int IMG_W      = 320,
  parameter int IMG_H      = 240,
  parameter int WORD_BYTES = 8,
  parameter int ADDR_W     = 16,
  parameter int Y_BASE     = 0,
  parameter int U_BASE     = 9600,
  parameter int V_BASE     = 14400,
  localparam int PW        = $clog2(WORD_BYTES * 8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              chroma_422,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [9:0]        req_row,
  input  logic [9:0]        req_col,
  input  logic              start,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [9:0]        out_row,
  output logic [9:0]        out_col,
  output logic [ADDR_W-1:0] y_addr,
  output logic [ADDR_W-1:0] u_addr,
  output logic [ADDR_W-1:0] v_addr,
  output logic [PW-1:0]     y_pos,
  output logic [PW-1:0]     c_pos,
  output logic              out_last,
  output logic              out_err,
  output logic              frame_done
);

  localparam int LOG_WB = $clog2(WORD_BYTES);
  localparam logic [9:0] LAST_ROW = 10'(IMG_H - 1);
  localparam logic [9:0] LAST_COL = 10'(IMG_W - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  scan_row_q, scan_row_d;
  logic [9:0]  scan_col_q, scan_col_d;

  // Both stages advance together; only a held output beat can block them.
  logic        en;

  logic        ins_valid;
  logic        ins_last;
  logic [9:0]  ins_row;
  logic [9:0]  ins_col;

  logic [9:0]  crow_c;
  logic [31:0] yi_c;
  logic [31:0] ci_c;

  logic        s1_valid;
  logic        s1_last;
  logic [9:0]  s1_row;
  logic [9:0]  s1_col;
  logic [31:0] s1_yi;
  logic [31:0] s1_ci;

`ifdef YUV_ADDR_BOUNDS_CHECK_EN
  logic        err_c;
  logic        s1_err;
`endif

  assign en         = !out_valid || out_ready;
  assign busy       = (state_q == SCAN);
  assign frame_done = out_valid && out_ready && out_last;

  // State and raster counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      scan_row_q <= '0;
      scan_col_q <= '0;
    end else begin
      state_q    <= state_d;
      scan_row_q <= scan_row_d;
      scan_col_q <= scan_col_d;
    end
  end

  // Next state, request handshake and selection of the coordinate to insert.
  always_comb begin
    state_d    = state_q;
    scan_row_d = scan_row_q;
    scan_col_d = scan_col_q;
    req_ready  = 1'b0;
    ins_valid  = 1'b0;
    ins_last   = 1'b0;
    ins_row    = req_row;
    ins_col    = req_col;
    case (state_q)
      IDLE: begin
        req_ready = en;
        ins_valid = req_valid && en;
        // An accepted request in the same cycle wins; the start is dropped.
        if (start && !(req_valid && en)) begin
          state_d    = SCAN;
          scan_row_d = '0;
          scan_col_d = '0;
        end
      end
      SCAN: begin
        ins_row = scan_row_q;
        ins_col = scan_col_q;
        if (en) begin
          ins_valid = 1'b1;
          if (scan_col_q == LAST_COL) begin
            scan_col_d = '0;
            if (scan_row_q == LAST_ROW) begin
              ins_last   = 1'b1;
              scan_row_d = '0;
              state_d    = IDLE;
            end else begin
              scan_row_d = scan_row_q + 10'd1;
            end
          end else begin
            scan_col_d = scan_col_q + 10'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Linear sample indices, computed at 32 bits so that nothing overflows
  // before the final truncation to ADDR_W.
  // In 4:2:0 a chroma row is shared by two luma rows; in 4:2:2 it is not.
  always_comb begin
    crow_c = chroma_422 ? ins_row : (ins_row >> 1);
    yi_c   = 32'(ins_row) * 32'(IMG_W) + 32'(ins_col);
    ci_c   = 32'(crow_c) * 32'(IMG_W / 2) + 32'(ins_col >> 1);
  end

`ifdef YUV_ADDR_BOUNDS_CHECK_EN
  assign err_c = (32'(ins_row) >= 32'(IMG_H)) || (32'(ins_col) >= 32'(IMG_W));
`endif

  // Stage 1: register the coordinate, its flags and the linear indices.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_row   <= '0;
      s1_col   <= '0;
      s1_yi    <= '0;
      s1_ci    <= '0;
`ifdef YUV_ADDR_BOUNDS_CHECK_EN
      s1_err   <= 1'b0;
`endif
    end else if (en) begin
      s1_valid <= ins_valid;
      s1_last  <= ins_last;
      s1_row   <= ins_row;
      s1_col   <= ins_col;
      s1_yi    <= yi_c;
      s1_ci    <= ci_c;
`ifdef YUV_ADDR_BOUNDS_CHECK_EN
      s1_err   <= err_c;
`endif
    end
  end

  // Stage 2: split each index into a word address and a bit offset.
  // WORD_BYTES is a power of two, so the split is a shift plus the low bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      y_addr    <= '0;
      u_addr    <= '0;
      v_addr    <= '0;
      y_pos     <= '0;
      c_pos     <= '0;
    end else if (en) begin
      out_valid <= s1_valid;
      out_last  <= s1_last;
      out_row   <= s1_row;
      out_col   <= s1_col;
`ifdef YUV_ADDR_BOUNDS_CHECK_EN
      if (s1_err) begin
        y_addr <= '0;
        u_addr <= '0;
        v_addr <= '0;
        y_pos  <= '0;
        c_pos  <= '0;
      end else begin
`endif
        y_addr <= ADDR_W'(32'(Y_BASE) + (s1_yi >> LOG_WB));
        u_addr <= ADDR_W'(32'(U_BASE) + (s1_ci >> LOG_WB));
        v_addr <= ADDR_W'(32'(V_BASE) + (s1_ci >> LOG_WB));
        y_pos  <= {s1_yi[LOG_WB-1:0], 3'b000};
        c_pos  <= {s1_ci[LOG_WB-1:0], 3'b000};
`ifdef YUV_ADDR_BOUNDS_CHECK_EN
      end
`endif
    end
  end

`ifdef YUV_ADDR_BOUNDS_CHECK_EN
  // The error flag travels with its beat and honours the same stall as the data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_err <= 1'b0;
    end else if (en) begin
      out_err <= s1_err;
    end
  end
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_yuv_addr_gen.sv
// Directed testbench for yuv_addr_gen with default parameters.
// Expected values are computed by hand for the default 320x240 frame
// with 8-byte memory words.

module tb_yuv_addr_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        chroma_422;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_row;
  logic [9:0]  req_col;
  logic        start;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_row;
  logic [9:0]  out_col;
  logic [15:0] y_addr;
  logic [15:0] u_addr;
  logic [15:0] v_addr;
  logic [5:0]  y_pos;
  logic [5:0]  c_pos;
  logic        out_last;
  logic        out_err;
  logic        frame_done;

  int n_assert = 0;
  int n_fail   = 0;

  yuv_addr_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .chroma_422 (chroma_422),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_row    (req_row),
    .req_col    (req_col),
    .start      (start),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_row    (out_row),
    .out_col    (out_col),
    .y_addr     (y_addr),
    .u_addr     (u_addr),
    .v_addr     (v_addr),
    .y_pos      (y_pos),
    .c_pos      (c_pos),
    .out_last   (out_last),
    .out_err    (out_err),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One request handshake, then advance to the cycle its beat is on the outputs.
  task automatic do_req(input int r, input int c, input logic c422);
    req_row    = 10'(r);
    req_col    = 10'(c);
    chroma_422 = c422;
    req_valid  = 1'b1;
    step();
    req_valid  = 1'b0;
    step();
  endtask

  task automatic check_beat(input string tag, input int r, input int c,
                            input int ya, input int ua, input int va,
                            input int yp, input int cp, input logic err);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".row"},   32'(out_row),   32'(r));
    check({tag, ".col"},   32'(out_col),   32'(c));
    check({tag, ".y"},     32'(y_addr),    32'(ya));
    check({tag, ".u"},     32'(u_addr),    32'(ua));
    check({tag, ".v"},     32'(v_addr),    32'(va));
    check({tag, ".ypos"},  32'(y_pos),     32'(yp));
    check({tag, ".cpos"},  32'(c_pos),     32'(cp));
    check({tag, ".err"},   32'(out_err),   32'(err));
    check({tag, ".last"},  32'(out_last),  32'd0);
  endtask

  initial begin
    int beats;
    int lasts;
    int fdones;
    int scan_bad;
    int er;
    int ec;
    int exp_y;
    int exp_u;
    logic exp_last;
    logic seen;

    rst_n      = 1'b0;
    chroma_422 = 1'b0;
    req_valid  = 1'b0;
    req_row    = '0;
    req_col    = '0;
    start      = 1'b0;
    out_ready  = 1'b1;
    step();
    step();

    // Reset state.
    check("rst.valid", 32'(out_valid),  32'd0);
    check("rst.busy",  32'(busy),       32'd0);
    check("rst.fdone", 32'(frame_done), 32'd0);
    check("rst.y",     32'(y_addr),     32'd0);
    check("rst.err",   32'(out_err),    32'd0);
    rst_n = 1'b1;
    step();
    check("idle.req_ready", 32'(req_ready), 32'd1);

    // Single requests with hand-computed addresses.
    do_req(0, 0, 1'b0);
    check_beat("t1", 0, 0, 0, 9600, 14400, 0, 0, 1'b0);
    do_req(1, 3, 1'b0);
    check_beat("t2", 1, 3, 40, 9600, 14400, 24, 8, 1'b0);
    do_req(239, 319, 1'b1);
    check_beat("t3_422", 239, 319, 9599, 14399, 19199, 56, 56, 1'b0);
    do_req(239, 319, 1'b0);
    check_beat("t3_420", 239, 319, 9599, 11999, 16799, 56, 56, 1'b0);
    do_req(240, 0, 1'b0);
`ifdef YUV_ADDR_BOUNDS_CHECK_EN
    check_beat("t4_oob", 240, 0, 0, 0, 0, 0, 0, 1'b1);
`else
    check_beat("t4_oob", 240, 0, 9600, 12000, 16800, 0, 0, 1'b0);
`endif
    step();
    check("drain.valid", 32'(out_valid), 32'd0);

    // Back-to-back requests: A=(2,5), B=(3,7), C=(4,9) with a 3-cycle stall on A.
    chroma_422 = 1'b0;
    req_valid  = 1'b1;
    req_row    = 10'd2;
    req_col    = 10'd5;
    step();
    req_row    = 10'd3;
    req_col    = 10'd7;
    step();
    out_ready  = 1'b0;
    req_row    = 10'd4;
    req_col    = 10'd9;
    #1;
    check("stall.req_ready0", 32'(req_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall.valid", 32'(out_valid), 32'd1);
      check("stall.row",   32'(out_row),   32'd2);
      check("stall.col",   32'(out_col),   32'd5);
      check("stall.y",     32'(y_addr),    32'd80);
      check("stall.ypos",  32'(y_pos),     32'd40);
      check("stall.u",     32'(u_addr),    32'd9620);
      check("stall.ready", 32'(req_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("stall.req_ready1", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    check_beat("bB", 3, 7, 120, 9620, 14420, 56, 24, 1'b0);
    step();
    check_beat("bC", 4, 9, 161, 9640, 14440, 8, 32, 1'b0);
    step();
    check("bC.after", 32'(out_valid), 32'd0);

    // Full raster scan in 4:2:0.
    start = 1'b1;
    step();
    start = 1'b0;
    check("scan.busy", 32'(busy), 32'd1);
    check("scan.req_ready", 32'(req_ready), 32'd0);
    beats    = 0;
    lasts    = 0;
    fdones   = 0;
    scan_bad = 0;
    for (int cyc = 0; cyc < 80000; cyc++) begin
      step();
      if (out_valid) begin
        er       = beats / 320;
        ec       = beats % 320;
        exp_y    = (er * 320 + ec) / 8;
        exp_u    = 9600 + ((er / 2) * 160 + ec / 2) / 8;
        exp_last = (beats == 76799);
        if (out_row !== 10'(er) || out_col !== 10'(ec) || y_addr !== 16'(exp_y) ||
            u_addr !== 16'(exp_u) || out_last !== exp_last || out_err !== 1'b0)
          scan_bad++;
        if (out_last)   lasts++;
        if (frame_done) fdones++;
        beats++;
      end
      if (!busy && !out_valid && beats > 0) break;
    end
    check("scan.beats",   32'(beats),    32'd76800);
    check("scan.order",   32'(scan_bad), 32'd0);
    check("scan.lasts",   32'(lasts),    32'd1);
    check("scan.fdone",   32'(fdones),   32'd1);
    check("scan.busy_end", 32'(busy),    32'd0);

    // Reset in the middle of a scan, then restart from (0,0).
    start = 1'b1;
    step();
    start = 1'b0;
    beats = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      if (out_valid) beats++;
      if (beats == 1000) break;
    end
    check("mid.beats", 32'(beats), 32'd1000);
    rst_n = 1'b0;
    step();
    check("mid.valid", 32'(out_valid),  32'd0);
    check("mid.busy",  32'(busy),       32'd0);
    check("mid.fdone", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    step();
    check("mid.idle_ready", 32'(req_ready), 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      step();
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("restart.seen", 32'(seen),    32'd1);
    check("restart.row",  32'(out_row), 32'd0);
    check("restart.col",  32'(out_col), 32'd0);
    check("restart.y",    32'(y_addr),  32'd0);
    check("restart.busy", 32'(busy),    32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
